// File: rtl/clock_time_core_if.sv
// Signal bundle between the time-of-day core and its stimulus/display side.
// Alarm signals exist only when CLOCK_TIME_ALARM_EN is defined.
interface clock_time_core_if;
    logic       sig1Hz;
    logic       run;
    logic       clr;
    logic       set_min;
    logic       set_hour;
    logic [7:0] sec_bcd;
    logic [7:0] min_bcd;
    logic [7:0] hour_bcd;
    logic       tick;
    logic       day_carry;
`ifdef CLOCK_TIME_ALARM_EN
    logic       alarm_on;
    logic [7:0] alarm_hour_bcd;
    logic [7:0] alarm_min_bcd;
    logic       alarm;
`endif

    modport master (
        output sig1Hz, run, clr, set_min, set_hour,
`ifdef CLOCK_TIME_ALARM_EN
        output alarm_on, alarm_hour_bcd, alarm_min_bcd,
        input  alarm,
`endif
        input  sec_bcd, min_bcd, hour_bcd, tick, day_carry
    );

    modport slave (
        input  sig1Hz, run, clr, set_min, set_hour,
`ifdef CLOCK_TIME_ALARM_EN
        input  alarm_on, alarm_hour_bcd, alarm_min_bcd,
        output alarm,
`endif
        output sec_bcd, min_bcd, hour_bcd, tick, day_carry
    );
endinterface

// File: rtl/clock_time_core.sv
// BCD hh:mm:ss counter advanced by rising edges of a 1 Hz strobe, with pause/set.
// Optional alarm compare enabled by defining CLOCK_TIME_ALARM_EN.
module clock_time_core #(
    parameter int HOUR_LIMIT = 24
) (
    input  logic                sysclk,
    input  logic                rst_n,
    clock_time_core_if.slave    bus
);
    localparam logic [7:0] HOUR_LAST =
        8'((((HOUR_LIMIT - 1) / 10) << 4) | ((HOUR_LIMIT - 1) % 10));
    localparam logic [7:0] BCD_59 = 8'h59;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    logic       sig1hz_d_reg;
    logic [7:0] sec_reg,  sec_next;
    logic [7:0] min_reg,  min_next;
    logic [7:0] hour_reg, hour_next;
    logic       tick_reg, tick_next;
    logic       day_carry_reg, day_carry_next;
    logic       sec_edge;

    assign sec_edge = bus.sig1Hz & ~sig1hz_d_reg;

    always_comb begin
        sec_next       = sec_reg;
        min_next       = min_reg;
        hour_next      = hour_reg;
        tick_next      = 1'b0;
        day_carry_next = 1'b0;
        if (bus.clr) begin
            sec_next  = 8'h00;
            min_next  = 8'h00;
            hour_next = 8'h00;
        end else if (bus.run && sec_edge) begin
            tick_next = 1'b1;
            if (sec_reg == BCD_59) begin
                sec_next = 8'h00;
                if (min_reg == BCD_59) begin
                    min_next = 8'h00;
                    if (hour_reg == HOUR_LAST) begin
                        hour_next      = 8'h00;
                        day_carry_next = 1'b1;
                    end else begin
                        hour_next = bcd_inc(hour_reg);
                    end
                end else begin
                    min_next = bcd_inc(min_reg);
                end
            end else begin
                sec_next = bcd_inc(sec_reg);
            end
        end else if (!bus.run) begin
            // Manual set never carries between fields and leaves seconds alone.
            if (bus.set_min)
                min_next = (min_reg == BCD_59) ? 8'h00 : bcd_inc(min_reg);
            if (bus.set_hour)
                hour_next = (hour_reg == HOUR_LAST) ? 8'h00 : bcd_inc(hour_reg);
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sig1hz_d_reg  <= 1'b0;
            sec_reg       <= 8'h00;
            min_reg       <= 8'h00;
            hour_reg      <= 8'h00;
            tick_reg      <= 1'b0;
            day_carry_reg <= 1'b0;
        end else begin
            sig1hz_d_reg  <= bus.sig1Hz;
            sec_reg       <= sec_next;
            min_reg       <= min_next;
            hour_reg      <= hour_next;
            tick_reg      <= tick_next;
            day_carry_reg <= day_carry_next;
        end
    end

    assign bus.sec_bcd   = sec_reg;
    assign bus.min_bcd   = min_reg;
    assign bus.hour_bcd  = hour_reg;
    assign bus.tick      = tick_reg;
    assign bus.day_carry = day_carry_reg;

`ifdef CLOCK_TIME_ALARM_EN
    // Compares the registered time, so the alarm trails the counters by one cycle.
    logic alarm_reg, alarm_next;

    assign alarm_next = bus.alarm_on
                        && (hour_reg == bus.alarm_hour_bcd)
                        && (min_reg  == bus.alarm_min_bcd);

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n)
            alarm_reg <= 1'b0;
        else
            alarm_reg <= alarm_next;
    end

    assign bus.alarm = alarm_reg;
`endif
endmodule

// File: tb/tb_clock_time_core.sv
// Directed bench for clock_time_core: a 24-hour and a 12-hour instance share stimulus.
module tb_clock_time_core;
    logic sysclk = 1'b0;
    logic rst_n  = 1'b0;
    always #5 sysclk = ~sysclk;

    clock_time_core_if b24();
    clock_time_core_if b12();

    assign b12.sig1Hz   = b24.sig1Hz;
    assign b12.run      = b24.run;
    assign b12.clr      = b24.clr;
    assign b12.set_min  = b24.set_min;
    assign b12.set_hour = b24.set_hour;
`ifdef CLOCK_TIME_ALARM_EN
    assign b12.alarm_on       = b24.alarm_on;
    assign b12.alarm_hour_bcd = b24.alarm_hour_bcd;
    assign b12.alarm_min_bcd  = b24.alarm_min_bcd;
`endif

    clock_time_core #(.HOUR_LIMIT(24)) dut24 (.sysclk(sysclk), .rst_n(rst_n), .bus(b24));
    clock_time_core #(.HOUR_LIMIT(12)) dut12 (.sysclk(sysclk), .rst_n(rst_n), .bus(b12));

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic        s, r, c, m, h;
        logic [23:0] t;
        logic        tk, dc;
    } vec_t;
    vec_t vt [15];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    // Inputs change on the falling edge; outputs are read 1 ns after the rising edge.
    task automatic step(input logic s, input logic r, input logic c, input logic m, input logic h);
        @(negedge sysclk);
        b24.sig1Hz   = s;
        b24.run      = r;
        b24.clr      = c;
        b24.set_min  = m;
        b24.set_hour = h;
        @(posedge sysclk);
        #1;
    endtask

    function automatic logic [31:0] st24();
        return 32'({b24.hour_bcd, b24.min_bcd, b24.sec_bcd, b24.tick, b24.day_carry});
    endfunction

    function automatic logic [31:0] st12();
        return 32'({b12.hour_bcd, b12.min_bcd, b12.sec_bcd, b12.tick, b12.day_carry});
    endfunction

    function automatic logic [31:0] exp_st(input logic [23:0] t, input logic tk, input logic dc);
        return 32'({t, tk, dc});
    endfunction

    task automatic adv(input int n);
        repeat (n) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic preload(input int h, input int m, input int s);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (h) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (m) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        adv(s);
    endtask

    initial begin
        int ticks;
        b24.sig1Hz = 0; b24.run = 0; b24.clr = 0; b24.set_min = 0; b24.set_hour = 0;
`ifdef CLOCK_TIME_ALARM_EN
        b24.alarm_on = 0; b24.alarm_hour_bcd = 8'h00; b24.alarm_min_bcd = 8'h00;
`endif
        // Reset state
        repeat (3) @(posedge sysclk);
        #1;
        chk("reset_state", st24(), exp_st(24'h000000, 1'b0, 1'b0));
        @(negedge sysclk);
        rst_n = 1'b1;

        // Three edges after release, each tick one cycle after its rise
        ticks = 0;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            ticks += int'(b24.tick);
            chk($sformatf("edge%0d_rise", k), st24(), exp_st(24'(k + 1), 1'b1, 1'b0));
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            ticks += int'(b24.tick);
            chk($sformatf("edge%0d_low", k), st24(), exp_st(24'(k + 1), 1'b0, 1'b0));
        end
        chk("tick_count", 32'(ticks), 32'd3);

        // Table-driven single-cycle vectors from 00:00:00
        vt[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000001, 1'b1, 1'b0};
        vt[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000001, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000001, 1'b0, 1'b0};
        vt[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000002, 1'b1, 1'b0};
        vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000102, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h010102, 1'b0, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h020202, 1'b0, 1'b0};
        vt[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h020202, 1'b0, 1'b0};
        vt[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h020202, 1'b0, 1'b0};
        vt[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 24'h020202, 1'b0, 1'b0};
        vt[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0};
        vt[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0};
        vt[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000001, 1'b1, 1'b0};
        vt[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000001, 1'b0, 1'b0};
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            step(vt[i].s, vt[i].r, vt[i].c, vt[i].m, vt[i].h);
            $display("vec %0d: in s%b r%b c%b m%b h%b -> %h:%h:%h tick %b dc %b", i,
                     vt[i].s, vt[i].r, vt[i].c, vt[i].m, vt[i].h,
                     b24.hour_bcd, b24.min_bcd, b24.sec_bcd, b24.tick, b24.day_carry);
            chk($sformatf("vec%0d", i), st24(), exp_st(vt[i].t, vt[i].tk, vt[i].dc));
        end

        // Seconds and minutes carries
        preload(0, 0, 59);
        chk("pre_000059", st24(), exp_st(24'h000059, 1'b0, 1'b0));
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("carry_000100", st24(), exp_st(24'h000100, 1'b1, 1'b0));
        preload(0, 59, 59);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("carry_010000", st24(), exp_st(24'h010000, 1'b1, 1'b0));

        // Day wrap: 23 set_hour pulses leave the 12-hour instance at 11
        preload(23, 59, 59);
        chk("pre_235959", st24(), exp_st(24'h235959, 1'b0, 1'b0));
        chk("pre12_115959", st12(), exp_st(24'h115959, 1'b0, 1'b0));
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("wrap24", st24(), exp_st(24'h000000, 1'b1, 1'b1));
        chk("wrap12_a", st12(), exp_st(24'h000000, 1'b1, 1'b1));
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("dc24_drop", st24(), exp_st(24'h000000, 1'b0, 1'b0));
        preload(11, 59, 59);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("noon24", st24(), exp_st(24'h120000, 1'b1, 1'b0));
        chk("wrap12_b", st12(), exp_st(24'h000000, 1'b1, 1'b1));

        // Set behaviour
        preload(3, 59, 0);
        chk("set_035900", st24(), exp_st(24'h035900, 1'b0, 1'b0));
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("set_min_wrap", st24(), exp_st(24'h030000, 1'b0, 1'b0));
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("set_both", st24(), exp_st(24'h040100, 1'b0, 1'b0));
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("set_while_run", st24(), exp_st(24'h040100, 1'b0, 1'b0));

        // Asynchronous reset mid-count
        preload(12, 34, 56);
        chk("pre_123456", st24(), exp_st(24'h123456, 1'b0, 1'b0));
        @(negedge sysclk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", st24(), exp_st(24'h000000, 1'b0, 1'b0));
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge sysclk);
        rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("after_release", st24(), exp_st(24'h000001, 1'b1, 1'b0));
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef CLOCK_TIME_ALARM_EN
        b24.alarm_hour_bcd = 8'h00;
        b24.alarm_min_bcd  = 8'h02;
        b24.alarm_on       = 1'b1;
        preload(0, 1, 59);
        chk("alarm_before", 32'(b24.alarm), 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("alarm_lag", {31'd0, b24.alarm} | {24'd0, b24.min_bcd} << 1, 32'h04);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("alarm_rise", 32'(b24.alarm), 32'd1);
        adv(59);
        chk("alarm_hold", {31'd0, b24.alarm} | {24'd0, b24.sec_bcd} << 1, 32'hB3);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("alarm_min3_lag", 32'(b24.alarm), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("alarm_fall", 32'(b24.alarm), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/clock_time_core.md
# clock_time_core

BCD time-of-day counter that consumes the 1 Hz square wave from the 1 Hz signal generator and keeps hours, minutes and seconds. It sits directly downstream of that generator in the `sysclk` domain and feeds the display/scan stage with packed BCD digits. It also provides a pause/set interface for manual time adjustment and an optional alarm compare.

## Interface
- `HOUR_LIMIT`, 24: hour modulus. Hours count 0..HOUR_LIMIT-1. Legal range 2..24.
- `sysclk` in 1: system clock, 50 MHz.
- `rst_n` in 1: asynchronous, active-low reset.
- `sig1Hz` in 1: 1 Hz square wave, synchronous to `sysclk`.
- `run` in 1: 1 = count seconds; 0 = paused, set inputs enabled.
- `clr` in 1: synchronous clear to 00:00:00.
- `set_min` in 1: single-cycle pulse; minutes +1 while paused.
- `set_hour` in 1: single-cycle pulse; hours +1 while paused.
- `sec_bcd` out 8: seconds, {tens[7:4], units[3:0]}.
- `min_bcd` out 8: minutes, same packing.
- `hour_bcd` out 8: hours, same packing.
- `tick` out 1: one-cycle pulse in the cycle the seconds value advances.
- `day_carry` out 1: one-cycle pulse on the wrap from (HOUR_LIMIT-1):59:59 to 00:00:00.

## Operation
- Edge detect: `sig1Hz_d` register captures `sig1Hz` every cycle, reset 0. `sec_edge = sig1Hz & ~sig1Hz_d`. Only the rising edge counts, giving one advance per second.
- Priority in each cycle, highest first:
  - `clr`: all counters go to 00, `tick`/`day_carry` stay 0.
  - `run=1 && sec_edge`: advance time.
  - `run=0`: apply `set_hour` and/or `set_min`.
- Advance:
  - Seconds units 9→0 carries into the tens digit. Seconds 59→00 carries into minutes.
  - Minutes 59→00 carries into hours.
  - Hours (HOUR_LIMIT-1)→00 asserts `day_carry`.
  - BCD units wrap 9→0 with a tens increment.
- Set:
  - `set_min` steps minutes 59→00 with no carry into hours.
  - `set_hour` steps hours modulo HOUR_LIMIT.
  - Both pulses in one cycle apply both steps.
  - Seconds are untouched by set.
  - Set pulses while `run=1` are ignored.
- Digits never take values above 9 (units) or above 5 (minute/second tens).
- Edge detector keeps updating during `clr` and while paused. A `sig1Hz` rising edge that occurs while paused is lost, not queued.

## Timing
- All outputs are registered. Reset values: `sec_bcd=min_bcd=hour_bcd=8'h00`, `tick=0`, `day_carry=0`.
- Latency: consider the first `sysclk` edge that samples `sig1Hz=1` while `sig1Hz_d=0`. The updated time and `tick=1` are visible after the next `sysclk` edge, i.e. one cycle after `sig1Hz` rises. `day_carry` asserts in the same cycle as the corresponding `tick`.
- Set pulses take effect one cycle after they are sampled.
- `rst_n` low mid-count: outputs go to reset values immediately. The first advance occurs on the first `sig1Hz` rising edge after release.
- `run` 0→1 while `sig1Hz` is already high: no advance until the next rising edge.

## Configuration
- `CLOCK_TIME_ALARM_EN` defined:
  - Adds input `alarm_on` (1 bit), inputs `alarm_hour_bcd` and `alarm_min_bcd` (8 bits each), and output `alarm` (1 bit, reset 0).
  - `alarm` is registered. It is 1 when `alarm_on=1` and `hour_bcd==alarm_hour_bcd` and `min_bcd==alarm_min_bcd`, so it stays high for the whole matching minute.
  - It lags the counter update by one cycle and drops one cycle after `alarm_on` falls.
- Not defined: those ports and their logic are absent. Counting behaviour is identical in both cases.

## Test plan
- Reset with `rst_n=0`, then release, `run=1`, 3 rising edges of `sig1Hz` -> `sec_bcd=8'h03`. Exactly 3 `tick` pulses, each one cycle after its `sig1Hz` rise.
- Preload 00:00:59 via set/clr, then 1 edge -> `sec_bcd=8'h00`, `min_bcd=8'h01`. Preload 00:59:59, then 1 edge -> 01:00:00.
- `HOUR_LIMIT=24` at 23:59:59, 1 edge -> 00:00:00 with `day_carry=1` for one cycle. With `HOUR_LIMIT=12` at 11:59:59 -> 00:00:00 with `day_carry`.
- `run=0`, 60 `set_min` pulses from 00 -> `min_bcd` back to 8'h00 with hours unchanged. `set_min`+`set_hour` together -> both increment. Set pulses with `run=1` -> no change.
- `clr` asserted in the same cycle as a `sec_edge` -> time 00:00:00, `tick=0`. Assert `rst_n` low mid-count at 12:34:56 -> immediate 00:00:00.
- With `CLOCK_TIME_ALARM_EN`: alarm 00:02, `alarm_on=1`, count from 00:01:59 -> `alarm` rises one cycle after `min_bcd=8'h02` and falls after the 00:02:59→00:03:00 advance.
